// File: rtl/mem_data_dirty_dump_ctrl.sv
// rtl/mem_data_dirty_dump_ctrl.sv - walks the dirty-bit table after CPU halt and streams dirty (addr, data) pairs
// Optional: define DIRTY_DUMP_COUNT_EN to add o_dirty_count (completed transfers in the current dump).
module mem_data_dirty_dump_ctrl #(
    parameter int RAM_DEPTH    = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_cpu_halted,
    input  logic                  i_bit_sucio,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_dump_ready,
    output logic [ADDR_W-1:0]     o_addr,
    output logic                  o_ena,
    output logic                  o_busy,
    output logic [ADDR_W-1:0]     o_dump_addr,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_valid,
`ifdef DIRTY_DUMP_COUNT_EN
    output logic [ADDR_W:0]       o_dirty_count,
`endif
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Terminal address is detected by equality so the pointer never needs to wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(READ_LATENCY);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [1:0]              lat_q, lat_d;
    logic [ADDR_W-1:0]       dump_addr_q, dump_addr_d;
    logic [DATA_WIDTH-1:0]   dump_data_q, dump_data_d;
`ifdef DIRTY_DUMP_COUNT_EN
    logic [ADDR_W:0]         cnt_q, cnt_d;
`endif

    // State and datapath registers; reset forces IDLE so every output drops at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            lat_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
`ifdef DIRTY_DUMP_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lat_q       <= lat_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
`ifdef DIRTY_DUMP_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state and outputs: scan clean words at one per cycle, read and hand off dirty ones.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lat_d        = lat_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
`ifdef DIRTY_DUMP_COUNT_EN
        cnt_d        = cnt_q;
`endif
        o_addr       = ptr_q;
        o_ena        = 1'b0;
        o_busy       = 1'b1;
        o_dump_valid = 1'b0;
        o_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start && i_cpu_halted) begin
                    state_d = S_CHECK;
                    ptr_d   = '0;
`ifdef DIRTY_DUMP_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_CHECK: begin
                if (i_bit_sucio) begin
                    state_d = S_READ;
                    lat_d   = '0;
                end else if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_READ: begin
                // Enable stays up READ_LATENCY+1 cycles; the last edge lands the memory output.
                o_ena = 1'b1;
                if (lat_q == LAT_LAST) begin
                    dump_addr_d = ptr_q;
                    dump_data_d = i_data;
                    state_d     = S_SEND;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_SEND: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) begin
`ifdef DIRTY_DUMP_COUNT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
                ptr_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign o_dump_addr = dump_addr_q;
    assign o_dump_data = dump_data_q;
`ifdef DIRTY_DUMP_COUNT_EN
    assign o_dirty_count = cnt_q;
`endif

endmodule

// File: tb/tb_mem_data_dirty_dump_ctrl.sv
// tb/tb_mem_data_dirty_dump_ctrl.sv - self-checking bench for mem_data_dirty_dump_ctrl
module tb_mem_data_dirty_dump_ctrl;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst, start, halted, ready, start2;
    logic ready2;
    logic [DW-1:0] mem [DEPTH];
    logic          dirty [DEPTH];

    logic [AW-1:0] addr1, daddr1, addr2, daddr2;
    logic [DW-1:0] data1, ddata1, data2, ddata2;
    logic ena1, busy1, valid1, done1, sucio1;
    logic ena2, busy2, valid2, done2, sucio2;
    logic [DW-1:0] rd1, p2a, p2b;
`ifdef DIRTY_DUMP_COUNT_EN
    logic [AW:0] cnt1, cnt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sucio1 = dirty[addr1];
    assign sucio2 = dirty[addr2];
    assign data1  = rd1;
    assign data2  = p2b;

    always @(posedge clk) if (ena1) rd1 <= mem[addr1];
    always @(posedge clk) begin
        if (ena2) p2a <= mem[addr2];
        p2b <= p2a;
    end

    mem_data_dirty_dump_ctrl #(.RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_cpu_halted(halted),
        .i_bit_sucio(sucio1), .i_data(data1), .i_dump_ready(ready),
        .o_addr(addr1), .o_ena(ena1), .o_busy(busy1), .o_dump_addr(daddr1),
        .o_dump_data(ddata1), .o_dump_valid(valid1),
`ifdef DIRTY_DUMP_COUNT_EN
        .o_dirty_count(cnt1),
`endif
        .o_done(done1)
    );

    mem_data_dirty_dump_ctrl #(.RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start2), .i_cpu_halted(halted),
        .i_bit_sucio(sucio2), .i_data(data2), .i_dump_ready(ready2),
        .o_addr(addr2), .o_ena(ena2), .o_busy(busy2), .o_dump_addr(daddr2),
        .o_dump_data(ddata2), .o_dump_valid(valid2),
`ifdef DIRTY_DUMP_COUNT_EN
        .o_dirty_count(cnt2),
`endif
        .o_done(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            dirty[i] = 1'b0;
            mem[i]   = $urandom;
        end
    endtask

    task automatic rand_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            dirty[i] = ($urandom_range(0, 3) == 0);
            mem[i]   = $urandom;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_ena"}, ena1, 0);
        chk({tag, "_valid"}, valid1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_addr"}, addr1, 0);
        chk({tag, "_daddr"}, daddr1, 0);
        chk({tag, "_ddata"}, ddata1, 0);
`ifdef DIRTY_DUMP_COUNT_EN
        chk({tag, "_count"}, cnt1, 0);
`endif
    endtask

    // mode 0: ready tied high; 1: random ready; 2: first pair stalled 5 cycles.
    // Expected busy length = 16 scan cycles + DONE + 3 per dirty word (2 READ + 1 SEND) + stalls.
    task automatic run_dump(input int mode);
        logic [AW-1:0] qa[$];
        logic [DW-1:0] qd[$];
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int nd = 0, stalls = 0, busy_cnt = 0, ena_cnt = 0, done_cyc = 0, run = 0, pairs = 0;
        bit prev_stall = 0, finished = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dirty[i]) begin
                qa.push_back(AW'(i));
                qd.push_back(mem[i]);
            end
        nd = qa.size();
        halted = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = !(pairs == 0 && run < 5);
            endcase
            if (busy1) busy_cnt++;
            if (ena1) ena_cnt++;
            if (valid1) begin
                chk("ena_during_send", ena1, 0);
                if (prev_stall) begin
                    chk("hold_addr", daddr1, pa);
                    chk("hold_data", ddata1, pd);
                end
                run++;
                if (ready) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_pair observed addr=%0h expected none", daddr1);
                    end else begin
                        chk("pair_addr", daddr1, qa.pop_front());
                        chk("pair_data", ddata1, qd.pop_front());
                    end
                    if (mode == 2 && pairs == 0) chk("stall_valid_cycles", run, 6);
                    pairs++;
                    run = 0;
                    prev_stall = 0;
                end else begin
                    stalls++;
                    prev_stall = 1;
                    pa = daddr1;
                    pd = ddata1;
                end
            end
            if (done1) begin
                done_cyc = cyc;
                finished = 1;
            end
            @(negedge clk);
        end
        chk("done_seen", finished, 1);
        chk("done_cycle", done_cyc, 17 + nd * 3 + stalls);
        chk("busy_cycles", busy_cnt, 17 + nd * 3 + stalls);
        chk("ena_cycles", ena_cnt, nd * 2);
        chk("pair_count", pairs, nd);
        chk("idle_after_busy", busy1, 0);
        chk("done_one_cycle", done1, 0);
`ifdef DIRTY_DUMP_COUNT_EN
        chk("dirty_count", cnt1, nd);
`endif
        ready = 1'b0;
    endtask

    initial begin
        int n;
        bit hit;
        int ena_hits;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; halted = 1'b0; ready = 1'b0; ready2 = 1'b1;
        clear_pattern();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Start while running CPU is dropped and not remembered.
        halted = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nohalt_busy", busy1, 0);
        repeat (3) @(negedge clk);
        halted = 1'b1;
        repeat (5) @(negedge clk);
        chk("nohalt_no_dump", busy1, 0);

        // All clean: 17 busy cycles, no pairs.
        clear_pattern();
        run_dump(0);

        // Dirty at 3 and 15.
        clear_pattern();
        dirty[3] = 1'b1;  mem[3]  = 32'hDEADBEEF;
        dirty[15] = 1'b1; mem[15] = 32'h12345678;
        run_dump(0);
        run_dump(2);

        // Reset while the addr-3 pair is being offered.
        halted = 1'b1;
        ready  = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (valid1 && daddr1 == 3) hit = 1;
            else @(negedge clk);
        end
        chk("reach_send3", hit, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_send_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_dump(0);

        // Randomized dumps against the queue model.
        for (int t = 0; t < 6; t++) begin
            rand_pattern();
            run_dump((t < 4) ? 1 : 0);
        end

        // Two-cycle read latency instance.
        clear_pattern();
        dirty[0] = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ena_hits = 0;
        hit = 0;
        n = 0;
        for (int i = 0; i < 60 && n == 0; i++) begin
            if (ena2 && addr2 == 0) ena_hits++;
            if (valid2) begin
                chk("lat2_addr", daddr2, 0);
                chk("lat2_data", ddata2, mem[0]);
                hit = 1;
            end
            if (done2) n = 1;
            @(negedge clk);
        end
        chk("lat2_pair_seen", hit, 1);
        chk("lat2_done", n, 1);
        chk("lat2_ena_cycles", ena_hits, 3);
        chk("lat1_untouched", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
